lin_approx_accumulator: RTL
===========================

Name: lin_approx_accumulator

Overview:
Consumes the ciphertext stream produced by the DES encryption block, together with the matching plaintext, and evaluates one linear approximation per sample: parity(PT & pt_mask) XOR parity(CT & ct_mask). It counts the samples for which the approximation holds (parity = 0) over a programmed number of samples. It then reports the count and the signed bias. It sits directly downstream of des_block in the key-search datapath and back-pressures it through ready_out.

Parameters:
DATA_W, 64, plaintext/ciphertext/mask width
CNT_W, 48, sample counter width (matches des_block counter)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: latch masks/num_samples, clear counters, enter RUN
pt_mask  in  DATA_W  plaintext mask, sampled on start
ct_mask  in  DATA_W  ciphertext mask, sampled on start
num_samples  in  CNT_W  samples to accumulate, sampled on start
plaintext_in  in  DATA_W  plaintext of current sample
ciphertext_in  in  DATA_W  ciphertext from des_block
valid_in  in  1  sample valid
ready_out  out  1  high only in RUN while accepted < num_samples
count_out  out  CNT_W  samples with approximation parity 0
samples_out  out  CNT_W  samples accepted
bias_out  out  CNT_W+1  signed 2*count_out - samples_out, updated on entry to DONE
done  out  1  high in DONE until the next start or rst

Behaviour:
- Reset (rst=1 at an edge): state IDLE; pipeline valids, count_out, samples_out, bias_out, ready_out and done all 0. The latched masks and num_samples are also cleared to 0.
- Accept: a sample is accepted when valid_in and ready_out are both high at the edge. Samples offered in IDLE, DRAIN or DONE are ignored.
- Pipeline, fixed two stages:
  - S1 registers w = (PT & pt_mask) ^ (CT & ct_mask) plus v1.
  - S2 registers p = XOR-reduce(w) plus v2.
  - On the edge after v2, count_out increments if p == 0.
  - samples_out increments on the accept edge itself.
- Latency: a sample accepted at edge E0 is reflected in count_out after E2.
- FSM IDLE -> RUN on start.
- RUN -> DRAIN on the edge where samples_out reaches num_samples. This can be the start edge itself when num_samples = 0.
- DRAIN -> DONE on the first edge where v1 = 0 and v2 = 0 and the final count update has completed. On that same edge, bias_out is registered and done is set.
- For the last sample accepted at E0: count is final after E2, and done = 1 after E3.
- DONE -> RUN on start.
- start in any state, including RUN or DRAIN: flush v1/v2, clear the counters, clear done, relatch the inputs, and enter RUN. start wins over a simultaneous valid_in, which is not accepted.
- rst wins over start.
- Widths:
  - samples_out is bounded by num_samples, so it never wraps.
  - count_out <= samples_out.
  - bias is computed in CNT_W+1 bits, two's complement.
- Gaps in valid_in are allowed. The pipeline advances every cycle and v-bits carry bubbles.

Decomposition:
- Shared package des_pkg holds:
  - DATA_W and CNT_W defaults
  - the FSM state encoding: IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3
- One sub-module, parity_reduce: a registered XOR-tree of DATA_W bits producing 1 bit, which forms stage S2.
- The FSM and counters stay in the top level.

Test Plan:
- Reset: hold rst for 3 cycles -> all outputs 0, ready_out = 0. Then pulse start with num_samples = 3 -> ready_out = 1 on the next cycle.
- pt_mask = 64'h1, ct_mask = 0, num_samples = 4; feed PT = 1, 0, 3, 2 back-to-back, CT = 0 -> count_out = 2, samples_out = 4, bias_out = 0, done 3 cycles after the last accept, ready_out drops right after the 4th accept.
- Both masks 0, num_samples = 5, valid_in toggling 1/0 -> count_out = 5, bias_out = +5. With pt_mask = ct_mask = 64'h8000_0000_0000_0001, PT = CT = 64'h1 -> count_out = 5.
- num_samples = 0 -> DRAIN then DONE with no accepts: count_out = 0, bias_out = 0, done = 1. valid_in asserted in IDLE/DONE -> samples_out unchanged.
- start mid-RUN after 2 of 6 samples, while a sample is still in flight -> counters return to 0, the in-flight sample is never counted, and the new run completes with exact new values.
- rst asserted in DRAIN -> all outputs 0 next cycle; no done pulse.

Source files
------------

// File: rtl/des_pkg.sv
// Shared widths and FSM encoding for the DES key-search datapath blocks.
package des_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/parity_reduce.sv
// Registered XOR reduction of a masked word to a single parity bit, with valid tag.
module parity_reduce #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] data,
    input  logic              valid_in,
    output logic              parity,
    output logic              valid_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            parity    <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            parity    <= ^data;
            valid_out <= flush ? 1'b0 : valid_in;
        end
    end

endmodule

// File: rtl/lin_approx_accumulator.sv
// Evaluates parity(PT & pt_mask) ^ parity(CT & ct_mask) per sample and accumulates
// the number of samples where the approximation holds, then reports count and bias.
module lin_approx_accumulator
    import des_pkg::*;
#(
    parameter int unsigned DATA_W = des_pkg::DATA_W,
    parameter int unsigned CNT_W  = des_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] pt_mask,
    input  logic [DATA_W-1:0] ct_mask,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [DATA_W-1:0] plaintext_in,
    input  logic [DATA_W-1:0] ciphertext_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [CNT_W-1:0]  count_out,
    output logic [CNT_W-1:0]  samples_out,
    output logic [CNT_W:0]    bias_out,
    output logic              done
);

    state_t              state;
    logic [DATA_W-1:0]   pt_mask_q;
    logic [DATA_W-1:0]   ct_mask_q;
    logic [CNT_W-1:0]    num_q;
    logic [DATA_W-1:0]   w_q;
    logic                v1;
    logic                p2;
    logic                v2;
    logic                accept;
    logic [CNT_W-1:0]    samples_inc;

    assign accept      = valid_in && ready_out;
    assign samples_inc = samples_out + CNT_W'(1);

    // Stage S2: parity of the masked word
    parity_reduce #(.DATA_W(DATA_W)) u_parity (
        .clk       (clk),
        .rst       (rst),
        .flush     (start),
        .data      (w_q),
        .valid_in  (v1),
        .parity    (p2),
        .valid_out (v2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pt_mask_q   <= '0;
            ct_mask_q   <= '0;
            num_q       <= '0;
            w_q         <= '0;
            v1          <= 1'b0;
            ready_out   <= 1'b0;
            count_out   <= '0;
            samples_out <= '0;
            bias_out    <= '0;
            done        <= 1'b0;
        end else if (start) begin
            // Restart from any state; an in-flight sample or a coincident offer is dropped
            pt_mask_q   <= pt_mask;
            ct_mask_q   <= ct_mask;
            num_q       <= num_samples;
            w_q         <= '0;
            v1          <= 1'b0;
            count_out   <= '0;
            samples_out <= '0;
            done        <= 1'b0;
            if (num_samples == '0) begin
                state     <= DRAIN;
                ready_out <= 1'b0;
            end else begin
                state     <= RUN;
                ready_out <= 1'b1;
            end
        end else begin
            w_q <= (plaintext_in & pt_mask_q) ^ (ciphertext_in & ct_mask_q);
            v1  <= accept;
            if (v2 && !p2) begin
                count_out <= count_out + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (accept) begin
                        samples_out <= samples_inc;
                        if (samples_inc == num_q) begin
                            state     <= DRAIN;
                            ready_out <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Both stages empty means the last count update has landed
                    if (!v1 && !v2) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        bias_out <= {count_out, 1'b0} - {1'b0, samples_out};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
